// File: rtl/blake2_digest_unloader_if.sv
// Processor-side read-back stream of the Blake2 digest unloader.
// The master drives words; the slave returns ready_in.
interface blake2_digest_unloader_if #(
  parameter int BUS_WIDTH = 64
);
  logic [BUS_WIDTH-1:0] dout;
  logic                 valid_out;
  logic                 last_out;
  logic                 ready_in;

  modport master (output dout, output valid_out, output last_out, input ready_in);
  modport slave  (input dout, input valid_out, input last_out, output ready_in);
endinterface

// File: rtl/blake2_digest_unloader.sv
// Captures engine digests on each digest_valid rise and streams them as BUS_WIDTH words, LSBs first.
// Optional macro DIGEST_DOUBLE_BUF_EN adds a pending digest register for gap-free back-to-back streams.
module blake2_digest_unloader #(
  parameter int BUS_WIDTH    = 64,
  parameter int DIGEST_WIDTH = 512,
  parameter int DIGEST_BYTES = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DIGEST_WIDTH-1:0]  digest,
  input  logic                     digest_valid,
  input  logic                     clear_overrun,
  blake2_digest_unloader_if.master bus,
  output logic                     busy,
  output logic                     digest_overrun
);
  localparam int N_WORDS = (DIGEST_BYTES * 8 + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int PAD_W   = N_WORDS * BUS_WIDTH;
  localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  // Bytes beyond DIGEST_BYTES are zeroed at capture so they can never reach dout.
  function automatic logic [PAD_W-1:0] mask_digest(input logic [DIGEST_WIDTH-1:0] d);
    logic [PAD_W-1:0] m;
    m = {PAD_W{1'b0}};
    for (int b = 0; b < DIGEST_BYTES; b++) begin
      m[8*b +: 8] = d[8*b +: 8];
    end
    return m;
  endfunction

  function automatic logic [BUS_WIDTH-1:0] word_at(input logic [PAD_W-1:0] s,
                                                   input logic [IDX_W-1:0] i);
    return s[BUS_WIDTH*int'(i) +: BUS_WIDTH];
  endfunction

  state_t               state_r, state_nxt_s;
  logic [IDX_W-1:0]     idx_r, idx_nxt_s;
  logic [PAD_W-1:0]     shadow_r, shadow_nxt_s;
  logic                 dv_r;
  logic                 overrun_r, overrun_nxt_s, overrun_set_s;
  logic [BUS_WIDTH-1:0] dout_r, dout_nxt_s;
  logic                 valid_r, valid_nxt_s;
  logic                 last_r, last_nxt_s;
  logic                 busy_r, busy_nxt_s;
  logic                 rise_s, hs_s, at_last_s;
`ifdef DIGEST_DOUBLE_BUF_EN
  logic [PAD_W-1:0]     pending_r, pending_nxt_s;
  logic                 pend_full_r, pend_full_nxt_s;
`endif

  assign rise_s    = digest_valid & ~dv_r;
  assign hs_s      = valid_r & bus.ready_in;
  assign at_last_s = (idx_r == LAST_IDX);

  // State register: FSM, word index, digest storage and edge-detect history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      idx_r       <= {IDX_W{1'b0}};
      shadow_r    <= {PAD_W{1'b0}};
      dv_r        <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef DIGEST_DOUBLE_BUF_EN
      pending_r   <= {PAD_W{1'b0}};
      pend_full_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      shadow_r    <= shadow_nxt_s;
      dv_r        <= digest_valid;
      overrun_r   <= overrun_nxt_s;
`ifdef DIGEST_DOUBLE_BUF_EN
      pending_r   <= pending_nxt_s;
      pend_full_r <= pend_full_nxt_s;
`endif
    end
  end

  // Next-state logic: capture, word advance, stream hand-over and overrun detection.
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    shadow_nxt_s  = shadow_r;
    overrun_set_s = 1'b0;
`ifdef DIGEST_DOUBLE_BUF_EN
    pending_nxt_s   = pending_r;
    pend_full_nxt_s = pend_full_r;
`endif
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          shadow_nxt_s = mask_digest(digest);
          idx_nxt_s    = {IDX_W{1'b0}};
          state_nxt_s  = SEND;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      SEND: begin
        if (hs_s && at_last_s) begin
          idx_nxt_s = {IDX_W{1'b0}};
`ifdef DIGEST_DOUBLE_BUF_EN
          if (pend_full_r) begin
            shadow_nxt_s = pending_r;
            if (rise_s) begin
              pending_nxt_s = mask_digest(digest);
            end else begin
              pend_full_nxt_s = 1'b0;
            end
          end else if (rise_s) begin
            shadow_nxt_s = mask_digest(digest);
          end else begin
            state_nxt_s = IDLE;
          end
`else
          if (rise_s) begin
            shadow_nxt_s = mask_digest(digest);
          end else begin
            state_nxt_s = IDLE;
          end
`endif
        end else begin
          if (hs_s) begin
            idx_nxt_s = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          end else begin
            idx_nxt_s = idx_r;
          end
          // A rise with no free slot drops the digest; the running stream is untouched.
`ifdef DIGEST_DOUBLE_BUF_EN
          if (rise_s && !pend_full_r) begin
            pending_nxt_s   = mask_digest(digest);
            pend_full_nxt_s = 1'b1;
          end else if (rise_s) begin
            overrun_set_s = 1'b1;
          end else begin
            overrun_set_s = 1'b0;
          end
`else
          if (rise_s) begin
            overrun_set_s = 1'b1;
          end else begin
            overrun_set_s = 1'b0;
          end
`endif
        end
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = {IDX_W{1'b0}};
      end
    endcase

    if (overrun_set_s) begin
      overrun_nxt_s = 1'b1;
    end else if (clear_overrun) begin
      overrun_nxt_s = 1'b0;
    end else begin
      overrun_nxt_s = overrun_r;
    end
  end

  // Output decode from next state so every output comes straight from a flop.
  always_comb begin
    valid_nxt_s = (state_nxt_s == SEND);
`ifdef DIGEST_DOUBLE_BUF_EN
    busy_nxt_s  = (state_nxt_s != IDLE) | pend_full_nxt_s;
`else
    busy_nxt_s  = (state_nxt_s != IDLE);
`endif
    if (state_nxt_s == SEND) begin
      dout_nxt_s = word_at(shadow_nxt_s, idx_nxt_s);
      last_nxt_s = (idx_nxt_s == LAST_IDX);
    end else begin
      dout_nxt_s = {BUS_WIDTH{1'b0}};
      last_nxt_s = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_r  <= {BUS_WIDTH{1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      dout_r  <= dout_nxt_s;
      valid_r <= valid_nxt_s;
      last_r  <= last_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  assign bus.dout       = dout_r;
  assign bus.valid_out  = valid_r;
  assign bus.last_out   = last_r;
  assign busy           = busy_r;
  assign digest_overrun = overrun_r;
endmodule

// File: tb/tb_blake2_digest_unloader.sv
// Bench for blake2_digest_unloader: a 64-byte and a 20-byte instance share stimulus and are
// checked each cycle against a word-queue reference model.
module tb_blake2_digest_unloader;
  logic         clk = 1'b0;
  logic         reset_n;
  logic [511:0] digest;
  logic         digest_valid;
  logic         clear_overrun;
  logic         ready_in;
  logic         busy_a, ovr_a, busy_b, ovr_b;
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  blake2_digest_unloader_if #(.BUS_WIDTH(64)) bus_a ();
  blake2_digest_unloader_if #(.BUS_WIDTH(64)) bus_b ();
  assign bus_a.ready_in = ready_in;
  assign bus_b.ready_in = ready_in;

  blake2_digest_unloader #(.BUS_WIDTH(64), .DIGEST_WIDTH(512), .DIGEST_BYTES(64)) dut_a (
    .clk(clk), .reset_n(reset_n), .digest(digest), .digest_valid(digest_valid),
    .clear_overrun(clear_overrun), .bus(bus_a), .busy(busy_a), .digest_overrun(ovr_a));

  blake2_digest_unloader #(.BUS_WIDTH(64), .DIGEST_WIDTH(512), .DIGEST_BYTES(20)) dut_b (
    .clk(clk), .reset_n(reset_n), .digest(digest), .digest_valid(digest_valid),
    .clear_overrun(clear_overrun), .bus(bus_b), .busy(busy_b), .digest_overrun(ovr_b));

  // Reference model: per instance, a queue of outstanding words plus the overrun flag.
  logic [63:0] exp_w [2][16];
  logic        exp_l [2][16];
  int          cnt [2];
  logic        exp_ovr [2];
  logic        prev_dv;

  function automatic int nw_of(input int k);
    return (k == 0) ? 8 : 3;
  endfunction

  function automatic int nb_of(input int k);
    return (k == 0) ? 64 : 20;
  endfunction

  function automatic int cap_of(input int k);
`ifdef DIGEST_DOUBLE_BUF_EN
    return 2 * nw_of(k);
`else
    return nw_of(k);
`endif
  endfunction

  function automatic logic [63:0] ref_word(input logic [511:0] d, input int j, input int nbytes);
    logic [63:0] w;
    w = 64'h0;
    for (int b = 0; b < 8; b++) begin
      if (j * 8 + b < nbytes) w[8*b +: 8] = d[8*(j*8+b) +: 8];
    end
    return w;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      cnt[k]     = 0;
      exp_ovr[k] = 1'b0;
    end
    prev_dv = 1'b0;
  endtask

  task automatic model_update();
    logic rise;
    logic ovr_set;
    if (!reset_n) begin
      model_clear();
    end else begin
      rise = digest_valid && !prev_dv;
      for (int k = 0; k < 2; k++) begin
        ovr_set = 1'b0;
        if (cnt[k] > 0 && ready_in) begin
          for (int i = 0; i < 15; i++) begin
            exp_w[k][i] = exp_w[k][i+1];
            exp_l[k][i] = exp_l[k][i+1];
          end
          cnt[k]--;
        end
        if (rise) begin
          if (cnt[k] <= cap_of(k) - nw_of(k)) begin
            for (int j = 0; j < nw_of(k); j++) begin
              exp_w[k][cnt[k]+j] = ref_word(digest, j, nb_of(k));
              exp_l[k][cnt[k]+j] = (j == nw_of(k) - 1);
            end
            cnt[k] += nw_of(k);
          end else begin
            ovr_set = 1'b1;
          end
        end
        if (ovr_set) exp_ovr[k] = 1'b1;
        else if (clear_overrun) exp_ovr[k] = 1'b0;
      end
      prev_dv = digest_valid;
    end
  endtask

  task automatic compare_all();
    check_val("valid_a", bus_a.valid_out, cnt[0] > 0);
    check_val("busy_a", busy_a, cnt[0] > 0);
    check_val("ovr_a", ovr_a, exp_ovr[0]);
    if (cnt[0] > 0) begin
      check_val("dout_a", bus_a.dout, exp_w[0][0]);
      check_val("last_a", bus_a.last_out, exp_l[0][0]);
    end
    check_val("valid_b", bus_b.valid_out, cnt[1] > 0);
    check_val("busy_b", busy_b, cnt[1] > 0);
    check_val("ovr_b", ovr_b, exp_ovr[1]);
    if (cnt[1] > 0) begin
      check_val("dout_b", bus_b.dout, exp_w[1][0]);
      check_val("last_b", bus_b.last_out, exp_l[1][0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic rand_digest();
    for (int i = 0; i < 16; i++) digest[32*i +: 32] = $urandom;
  endtask

  task automatic pulse_digest();
    digest_valid = 1'b1;
    step();
    digest_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_dout_a"}, bus_a.dout, 64'h0);
    check_val({tag, "_last_a"}, bus_a.last_out, 64'h0);
    check_val({tag, "_dout_b"}, bus_b.dout, 64'h0);
    check_val({tag, "_last_b"}, bus_b.last_out, 64'h0);
  endtask

  initial begin
    reset_n = 1'b0; digest = 512'h0; digest_valid = 1'b0;
    clear_overrun = 1'b0; ready_in = 1'b0;
    model_clear();
    #1;
    compare_all();
    check_reset_outputs("rst");
    step(); step();
    reset_n = 1'b1;

    // Byte-ramp digest, ready always high.
    for (int k = 0; k < 64; k++) digest[8*k +: 8] = k[7:0];
    ready_in = 1'b1;
    pulse_digest();
    check_val("t1_word0_a", bus_a.dout, 64'h0706050403020100);
    step(); step();
    check_val("t3_word2_b", bus_b.dout, 64'h0000000013121110);
    check_val("t3_last_b", bus_b.last_out, 64'h1);
    repeat (8) step();
    check_val("t1_busy_done", busy_a, 64'h0);

    // Stalling consumer.
    ready_in = 1'b0;
    pulse_digest();
    for (int i = 0; i < 40; i++) begin
      ready_in = (i % 3 == 0);
      step();
    end

    // digest_valid held high: only one stream.
    ready_in = 1'b1;
    rand_digest();
    digest_valid = 1'b1;
    repeat (20) step();
    digest_valid = 1'b0;
    repeat (4) step();
    check_val("t4_busy_done", busy_a, 64'h0);

    // Second rise mid-stream, then clear_overrun.
    rand_digest();
    pulse_digest();
    step(); step();
    rand_digest();
    pulse_digest();
    repeat (20) step();
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    step();
    check_val("t5_ovr_clr", ovr_a, 64'h0);

    // Rise coinciding with the final handshake.
    rand_digest();
    pulse_digest();
    repeat (7) step();
    rand_digest();
    pulse_digest();
    repeat (12) step();

    // Async reset mid-stream, then restart.
    rand_digest();
    pulse_digest();
    repeat (4) step();
    reset_n = 1'b0;
    model_clear();
    #1;
    compare_all();
    check_reset_outputs("t6_rst");
    step(); step();
    reset_n = 1'b1;
    rand_digest();
    pulse_digest();
    repeat (10) step();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      rand_digest();
      digest_valid  = ($urandom_range(0, 3) == 0);
      ready_in      = ($urandom_range(0, 3) != 0);
      clear_overrun = ($urandom_range(0, 15) == 0);
      step();
    end
    digest_valid = 1'b0; clear_overrun = 1'b0; ready_in = 1'b1;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
